// File: rtl/req_arbiter8.sv
`timescale 1ns/1ps
// req_arbiter8: eight-way request arbiter with fixed or round-robin priority,
// registered one-hot grant and an optional per-ownership hold limit.
module req_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rr_en,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] grant_nxt;
  logic [2:0] grant_id_nxt;
  logic [2:0] last_id;
  logic [2:0] last_id_nxt;
  logic [7:0] hold_cnt;
  logic [7:0] hold_cnt_nxt;
  logic       timeout_nxt;

  logic       win_any;
  logic [2:0] win_id;
  logic       win_any_mask;
  logic [2:0] win_id_mask;

  // Returns {found, index}. Fixed mode: highest set index. Round-robin:
  // last-1 is highest priority, wrapping down to last as lowest.
  function automatic logic [3:0] arbitrate(input logic [7:0] cand,
                                           input logic       rr,
                                           input logic [2:0] last);
    logic       found;
    logic [2:0] idx;
    logic [2:0] pos;
    found = 1'b0;
    idx   = 3'd0;
    pos   = 3'd0;
    if (!rr) begin
      for (int i = 0; i < 8; i++) begin
        if (cand[i]) begin
          found = 1'b1;
          idx   = 3'(i);
        end
      end
    end else begin
      // Scan from lowest to highest priority so the final hit wins.
      for (int j = 8; j >= 1; j--) begin
        pos = last - 3'(j);
        if (cand[pos]) begin
          found = 1'b1;
          idx   = pos;
        end
      end
    end
    return {found, idx};
  endfunction

  assign {win_any, win_id}           = arbitrate(req, rr_en, last_id);
  assign {win_any_mask, win_id_mask} = arbitrate(req & ~grant, rr_en, last_id);

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    last_id_nxt  = last_id;
    hold_cnt_nxt = hold_cnt;
    timeout_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (win_any) begin
          state_nxt    = OWN;
          grant_nxt    = 8'd1 << win_id;
          grant_id_nxt = win_id;
          last_id_nxt  = win_id;
          hold_cnt_nxt = 8'd0;
        end
      end

      OWN: begin
        if (!req[grant_id]) begin
          // Release takes precedence over a coincident timeout.
          if (win_any) begin
            grant_nxt    = 8'd1 << win_id;
            grant_id_nxt = win_id;
            last_id_nxt  = win_id;
            hold_cnt_nxt = 8'd0;
          end else begin
            state_nxt = IDLE;
            grant_nxt = 8'd0;
          end
        end else if (HOLD_EN && (hold_cnt == HOLD_LAST)) begin
          timeout_nxt = 1'b1;
          if (win_any_mask) begin
            grant_nxt    = 8'd1 << win_id_mask;
            grant_id_nxt = win_id_mask;
            last_id_nxt  = win_id_mask;
            hold_cnt_nxt = 8'd0;
          end else begin
            state_nxt = IDLE;
            grant_nxt = 8'd0;
          end
        end else if (hold_cnt != 8'hFF) begin
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 8'd0;
      grant_id <= 3'd0;
      last_id  <= 3'd0;
      hold_cnt <= 8'd0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
      last_id  <= last_id_nxt;
      hold_cnt <= hold_cnt_nxt;
      valid    <= |grant_nxt;
      timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_req_arbiter8.sv
`timescale 1ns/1ps
// tb_req_arbiter8: scenario tasks for req_arbiter8 across several MAX_HOLD
// settings, with expected outputs queued at drive time and checked after the edge.
module tb_req_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rr_en;

  always #5 clk = ~clk;

  logic [7:0] g16, g0, g4, g3, g2;
  logic [2:0] id16, id0, id4, id3, id2;
  logic       v16, v0, v4, v3, v2;
  logic       t16, t0, t4, t3, t2;

  req_arbiter8 #(.MAX_HOLD(16)) u_h16 (.clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
    .grant(g16), .grant_id(id16), .valid(v16), .timeout(t16));
  req_arbiter8 #(.MAX_HOLD(0)) u_h0 (.clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
    .grant(g0), .grant_id(id0), .valid(v0), .timeout(t0));
  req_arbiter8 #(.MAX_HOLD(4)) u_h4 (.clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
    .grant(g4), .grant_id(id4), .valid(v4), .timeout(t4));
  req_arbiter8 #(.MAX_HOLD(3)) u_h3 (.clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
    .grant(g3), .grant_id(id3), .valid(v3), .timeout(t3));
  req_arbiter8 #(.MAX_HOLD(2)) u_h2 (.clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
    .grant(g2), .grant_id(id2), .valid(v2), .timeout(t2));

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] id;
    logic       v;
    logic       t;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Expected-value constructor; grant_id is only meaningful while valid.
  function automatic exp_t mk(input logic [7:0] g, input logic [2:0] id, input logic t);
    exp_t e;
    e.g  = g;
    e.v  = |g;
    e.id = (|g) ? id : 3'd0;
    e.t  = t;
    return e;
  endfunction

  task automatic apply_reset;
    rst_n = 1'b0;
    req   = 8'h00;
    rr_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    exp_t exp_v;
    exp_t act;
    rst_n = 1'b0;
    req   = 8'h00;
    rr_en = 1'b0;
    #1;
    sb.push_back('0);
    sb.push_back('0);
    exp_v = sb.pop_front();
    act   = {g16, id16, v16, t16};
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL reset_h16: got %h, want %h", act, exp_v);
    end
    exp_v = sb.pop_front();
    act   = {g4, id4, v4, t4};
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL reset_h4: got %h, want %h", act, exp_v);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fixed;
    logic [7:0] rq  [6];
    logic [7:0] eg  [6];
    logic [2:0] eid [6];
    exp_t       exp_v;
    exp_t       act;
    rq  = '{8'h26, 8'h06, 8'h86, 8'h82, 8'h00, 8'h00};
    eg  = '{8'h20, 8'h04, 8'h04, 8'h80, 8'h00, 8'h00};
    eid = '{3'd5, 3'd2, 3'd2, 3'd7, 3'd0, 3'd0};
    apply_reset();
    rr_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req = rq[i];
      sb.push_back(mk(eg[i], eid[i], 1'b0));
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      act   = {g16, (exp_v.v ? id16 : 3'd0), v16, t16};
      n_tests++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL fixed step %0d: got g=%b id=%0d v=%b t=%b, want g=%b id=%0d v=%b t=%b",
                 i, act.g, act.id, act.v, act.t, exp_v.g, exp_v.id, exp_v.v, exp_v.t);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] ord [3];
    logic [7:0] rq  [13];
    logic [2:0] eo  [13];
    exp_t       exp_v;
    exp_t       act;
    ord = '{3'd7, 3'd3, 3'd0};
    rq[0] = 8'h89;
    eo[0] = 3'd7;
    for (int r = 0; r < 6; r++) begin
      rq[1 + 2*r] = 8'h89;
      eo[1 + 2*r] = ord[r % 3];
      rq[2 + 2*r] = 8'h89 & ~(8'd1 << ord[r % 3]);
      eo[2 + 2*r] = ord[(r + 1) % 3];
    end
    apply_reset();
    rr_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      req = rq[i];
      sb.push_back(mk(8'd1 << eo[i], eo[i], 1'b0));
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      act   = {g0, (exp_v.v ? id0 : 3'd0), v0, t0};
      n_tests++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL round_robin step %0d: got g=%b id=%0d v=%b t=%b, want g=%b id=%0d v=%b t=%b",
                 i, act.g, act.id, act.v, act.t, exp_v.g, exp_v.id, exp_v.v, exp_v.t);
      end
    end
    rr_en = 1'b0;
  endtask

  task automatic test_timeout;
    logic [2:0] eid [10];
    logic       et  [10];
    exp_t       exp_v;
    exp_t       act;
    eid = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7};
    et  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      req = 8'h81;
      sb.push_back(mk(8'd1 << eid[i], eid[i], et[i]));
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      act   = {g4, (exp_v.v ? id4 : 3'd0), v4, t4};
      n_tests++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL timeout step %0d: got g=%b id=%0d v=%b t=%b, want g=%b id=%0d v=%b t=%b",
                 i, act.g, act.id, act.v, act.t, exp_v.g, exp_v.id, exp_v.v, exp_v.t);
      end
    end
  endtask

  task automatic test_lone_timeout;
    logic [7:0] eg [8];
    logic       et [8];
    exp_t       exp_v;
    exp_t       act;
    eg = '{8'h10, 8'h10, 8'h10, 8'h00, 8'h10, 8'h10, 8'h10, 8'h00};
    et = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      req = 8'h10;
      sb.push_back(mk(eg[i], 3'd4, et[i]));
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      act   = {g3, (exp_v.v ? id3 : 3'd0), v3, t3};
      n_tests++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL lone_timeout step %0d: got g=%b id=%0d v=%b t=%b, want g=%b id=%0d v=%b t=%b",
                 i, act.g, act.id, act.v, act.t, exp_v.g, exp_v.id, exp_v.v, exp_v.t);
      end
    end
  endtask

  task automatic test_release_vs_timeout;
    logic [7:0] rq  [6];
    logic [7:0] eg  [6];
    logic [2:0] eid [6];
    logic       et  [6];
    exp_t       exp_v;
    exp_t       act;
    rq  = '{8'h06, 8'h06, 8'h02, 8'h02, 8'h02, 8'h00};
    eg  = '{8'h04, 8'h04, 8'h02, 8'h02, 8'h00, 8'h00};
    eid = '{3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
    et  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      req = rq[i];
      sb.push_back(mk(eg[i], eid[i], et[i]));
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      act   = {g2, (exp_v.v ? id2 : 3'd0), v2, t2};
      n_tests++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL release_vs_timeout step %0d: got g=%b id=%0d v=%b t=%b, want g=%b id=%0d v=%b t=%b",
                 i, act.g, act.id, act.v, act.t, exp_v.g, exp_v.id, exp_v.v, exp_v.t);
      end
    end
  endtask

  task automatic test_async_reset;
    exp_t exp_v;
    exp_t act;
    apply_reset();
    req = 8'hFF;
    sb.push_back(mk(8'h80, 3'd7, 1'b0));
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    act   = {g16, (exp_v.v ? id16 : 3'd0), v16, t16};
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL async_pre_own: got %h, want %h", act, exp_v);
    end
    // Mid-cycle reset must clear outputs before the next rising edge.
    #2;
    rst_n = 1'b0;
    sb.push_back(mk(8'h00, 3'd0, 1'b0));
    #1;
    exp_v = sb.pop_front();
    act   = {g16, 3'd0, v16, t16};
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL async_mid_cycle: got g=%b v=%b t=%b, want g=%b v=%b t=%b",
               act.g, act.v, act.t, exp_v.g, exp_v.v, exp_v.t);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 8'hFF;
    sb.push_back(mk(8'h80, 3'd7, 1'b0));
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    act   = {g16, (exp_v.v ? id16 : 3'd0), v16, t16};
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL async_post_reset: got g=%b id=%0d v=%b t=%b, want g=%b id=%0d v=%b t=%b",
               act.g, act.id, act.v, act.t, exp_v.g, exp_v.id, exp_v.v, exp_v.t);
    end
    req = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    rr_en = 1'b0;
    #2;
    test_reset();
    test_fixed();
    test_round_robin();
    test_timeout();
    test_lone_timeout();
    test_release_vs_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/req_arbiter8.md
# req_arbiter8

Eight-way bus arbiter that shares one resource among eight requesters. It uses highest-index-wins priority encoding, with an optional round-robin rotation and a hold-time limit. It sits between the requester ports and the shared datapath, drives a one-hot grant plus a 3-bit encoded owner ID, and registers every decision so downstream muxes see stable selects for the whole ownership period.

## Interface
- MAX_HOLD, 16: maximum consecutive grant cycles per ownership, range 0..255; 0 = unlimited.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- req  input  8  request vector; requester i holds req[i] high for as long as it wants or uses the resource.
- rr_en  input  1  1 = round-robin priority, 0 = fixed priority (index 7 highest, index 0 lowest).
- grant  output  8  one-hot grant, registered; all-zero when idle.
- grant_id  output  3  binary index of current owner, registered; valid only when valid=1.
- valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on the edge at which an owner is forcibly released by MAX_HOLD.

## Operation
- States: IDLE (no owner) and OWN (grant[grant_id]=1). Registers: state, grant, grant_id, last_id[2:0], hold_cnt[7:0].
- Arbitration function: selects a winner from a candidate vector.
  - rr_en=0: the highest set index wins.
  - rr_en=1: search order is last_id-1, last_id-2, … wrapping modulo 8, ending at last_id, which is lowest priority.
  - rr_en is sampled only at the edge where arbitration happens.
- IDLE:
  - If req≠0, arbitrate over req, go to OWN, load grant/grant_id/last_id with the winner, and set hold_cnt=0.
  - Otherwise stay in IDLE.
- OWN, release (req[grant_id]=0):
  - Arbitrate over req at the same edge.
  - If req≠0, the new winner is granted back-to-back with no idle cycle and hold_cnt=0.
  - Otherwise go to IDLE, with grant=0 and valid=0.
- OWN, timeout (MAX_HOLD≠0, req[grant_id]=1, hold_cnt=MAX_HOLD-1):
  - Pulse timeout.
  - Arbitrate over req with the owner bit masked.
  - If any other request exists, grant it back-to-back.
  - Otherwise go to IDLE for at least one cycle; the former owner may win again from IDLE.
- OWN, otherwise: stay and increment hold_cnt, saturating at 255.
- No preemption: a higher-priority request never interrupts an owner before release or timeout.
- Requests from non-owners that rise and fall while another requester owns the resource are not remembered.
- Simultaneous release and timeout on the same edge: release wins and timeout stays 0.
- grant is always one-hot or zero.
- grant_id and last_id keep their values in IDLE.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, grant=0, grant_id=0, valid=0, timeout=0, last_id=0, hold_cnt=0.
  - last_id=0 makes the first round-robin search order 7,6,…,0, identical to fixed priority.
- Reset asserted mid-ownership clears grant immediately, without waiting for a clock edge.
- Deassertion is assumed synchronised externally; the first arbitration happens on the first rising edge with rst_n high.
- Latency: req rising at edge k is sampled at edge k; grant is visible after edge k, i.e. one cycle.
- Owner release: req[grant_id] low sampled at edge k; grant changes after edge k.
- Maximum ownership is exactly MAX_HOLD cycles with valid=1 for one owner.
- timeout is high for exactly the one cycle following the forcing edge.
- valid = |grant, and is registered.

## Test plan
- Fixed priority, basic:
  - Reset; rr_en=0, req=8'b0010_0110 -> one cycle later grant=8'b0010_0000, grant_id=5, valid=1.
  - Drop req[5] -> next cycle grant_id=2 with no idle gap.
- Round-robin fairness: rr_en=1, MAX_HOLD=0; requesters 7, 3 and 0 each pulse req low for one cycle after two granted cycles -> grant order 7, 3, 0, 7, 3, 0 …
- Timeout: MAX_HOLD=4, req=8'h81 held -> grant_id=7 for exactly 4 cycles, then timeout=1 for one cycle and grant_id=0.
  - After 4 more cycles, grant_id=7 again.
- Timeout with a lone requester: MAX_HOLD=3, req=8'h10 held -> 3 cycles granted, timeout pulse, one cycle with valid=0, then re-granted to 4.
- Simultaneous release and timeout: MAX_HOLD=2, owner drops req on its last cycle -> timeout stays 0 and the next requester is granted.
- Asynchronous reset during OWN: assert rst_n=0 mid-cycle -> grant, valid and timeout go to 0 before the next clock edge.
  - After release, req=8'hFF -> grant_id=7.
